burst_mem_responder: RTL and testbench

BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

---
 rtl/mem_burst_pkg.sv | 20 ++
 rtl/burst_line_ram.sv | 29 ++
 rtl/burst_mem_responder.sv | 129 ++++++++++++
 tb/tb_burst_mem_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_burst_pkg.sv
// rtl/mem_burst_pkg.sv - shared widths, FSM state and beat index types for the burst responder
package mem_burst_pkg;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;
    localparam int LINE_W = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST,
        ST_DONE
    } state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_e;

    typedef logic [1:0] beat_idx_t;
endpackage

// File: rtl/burst_line_ram.sv
// rtl/burst_line_ram.sv - line store with registered full-line read and per-beat write enables
module burst_line_ram
    import mem_burst_pkg::*;
#(
    parameter int DEPTH_LINES = 16,
    localparam int IDX_W = $clog2(DEPTH_LINES)
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [LINE_W-1:0] rdata_o,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [BEATS-1:0]  we_i,
    input  logic [BEAT_W-1:0] wdata_i
);
    logic [LINE_W-1:0] mem_q [DEPTH_LINES];
    logic [LINE_W-1:0] rdata_q;

    // No reset on the array so contents survive a responder reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BEATS; b++) begin
            if (we_i[b]) begin
                mem_q[waddr_i][b*BEAT_W +: BEAT_W] <= wdata_i;
            end
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - fixed-latency 4-beat line read/write responder
module burst_mem_responder
    import mem_burst_pkg::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [31:0]       address_i,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic              resp_o,
    output logic              proto_err_o,
    output logic [31:0]       read_count_o,
    output logic [31:0]       write_count_o
);
    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam logic [3:0] LAT_LOAD = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        lat_q, lat_d;
    beat_idx_t         beat_q, beat_d;
    logic              proto_q, proto_d;
    logic [31:0]       rd_cnt_q, rd_cnt_d;
    logic [31:0]       wr_cnt_q, wr_cnt_d;

    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  raddr;
    logic [LINE_W-1:0] line_rdata;
    logic [BEATS-1:0]  we;
    logic              unused_addr;

    assign req_idx     = address_i[IDX_W+4:5];
    assign unused_addr = ^{address_i[31:IDX_W+5], address_i[4:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_READ;
            idx_q    <= '0;
            lat_q    <= '0;
            beat_q   <= '0;
            proto_q  <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            lat_q    <= lat_d;
            beat_q   <= beat_d;
            proto_q  <= proto_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        idx_d    = idx_q;
        lat_d    = lat_q;
        beat_d   = beat_q;
        proto_d  = proto_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (read_i || write_i) begin
                    // A simultaneous read+write is served as a read and flagged.
                    op_d    = read_i ? OP_READ : OP_WRITE;
                    idx_d   = req_idx;
                    lat_d   = LAT_LOAD;
                    beat_d  = '0;
                    proto_d = proto_q | (read_i & write_i);
                    state_d = (LATENCY > 0) ? ST_WAIT : ST_BURST;
                end
            end
            ST_WAIT: begin
                if (lat_q == 4'd0) begin
                    state_d = ST_BURST;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            ST_BURST: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (op_q == OP_READ) begin
                    if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 32'd1;
                end else begin
                    if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 32'd1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // In IDLE the RAM reads the incoming address so beat 0 is ready even with zero latency.
    assign raddr = (state_q == ST_IDLE) ? req_idx : idx_q;
    assign we    = (resp_o && op_q == OP_WRITE) ? 4'(4'b0001 << beat_q) : '0;

    burst_line_ram #(
        .DEPTH_LINES(DEPTH_LINES)
    ) u_ram (
        .clk     (clk),
        .raddr_i (raddr),
        .rdata_o (line_rdata),
        .waddr_i (idx_q),
        .we_i    (we),
        .wdata_i (burst_i)
    );

    assign resp_o        = (state_q == ST_BURST);
    assign burst_o       = resp_o ? line_rdata[{beat_q, 6'd0} +: BEAT_W] : '0;
    assign proto_err_o   = proto_q;
    assign read_count_o  = rd_cnt_q;
    assign write_count_o = wr_cnt_q;
endmodule

// File: tb/tb_burst_mem_responder.sv
// tb/tb_burst_mem_responder.sv - scoreboard bench for burst_mem_responder against a line-array model
module tb_burst_mem_responder;
    localparam int LAT    = 4;
    localparam int NLINES = 16;

    typedef logic [255:0] line_t;
    typedef struct {
        bit          is_rd;
        int          tag;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_i = 1'b0, write_i = 1'b0;
    logic [31:0] address_i = '0;
    logic [63:0] burst_i = '0;
    logic [63:0] burst_o;
    logic        resp_o, proto_err_o;
    logic [31:0] read_count_o, write_count_o;

    logic        z_read = 1'b0, z_write = 1'b0;
    logic [31:0] z_addr = '0;
    logic [63:0] z_burst_i = '0;
    logic [63:0] z_burst_o;
    logic        z_resp, z_proto;
    logic [31:0] z_rdcnt, z_wrcnt;

    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    exp_t  exp_q[$];
    exp_t  mon_e;
    line_t model_mem [NLINES];
    int    model_rd = 0, model_wr = 0;
    bit    model_proto = 1'b0;
    int    free_cyc = 0;

    burst_mem_responder #(.LATENCY(LAT), .DEPTH_LINES(NLINES)) dut (
        .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i),
        .address_i(address_i), .burst_i(burst_i), .burst_o(burst_o),
        .resp_o(resp_o), .proto_err_o(proto_err_o),
        .read_count_o(read_count_o), .write_count_o(write_count_o)
    );

    burst_mem_responder #(.LATENCY(0), .DEPTH_LINES(NLINES)) dut0 (
        .clk(clk), .rst(rst), .read_i(z_read), .write_i(z_write),
        .address_i(z_addr), .burst_i(z_burst_i), .burst_o(z_burst_o),
        .resp_o(z_resp), .proto_err_o(z_proto),
        .read_count_o(z_rdcnt), .write_count_o(z_wrcnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int line_of(input logic [31:0] addr);
        return int'((addr >> 5) % 32'(NLINES));
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (resp_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_cycle", 64'(cyc), 64'(mon_e.tag));
                    if (mon_e.is_rd) check("beat_data", burst_o, mon_e.data);
                end
            end else begin
                check("idle_burst_zero", burst_o, 64'd0);
                if (exp_q.size() != 0 && exp_q[0].tag <= cyc) begin
                    check("missing_beat", 64'(cyc), 64'(exp_q[0].tag - 1));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        read_i = 1'b0;
        write_i = 1'b0;
        exp_q.delete();
        #1;
        check("rst_resp", 64'(resp_o), 64'd0);
        check("rst_burst", burst_o, 64'd0);
        check("rst_proto", 64'(proto_err_o), 64'd0);
        check("rst_rdcnt", 64'(read_count_o), 64'd0);
        check("rst_wrcnt", 64'(write_count_o), 64'd0);
        step();
        step();
        rst = 1'b1;
        model_rd = 0;
        model_wr = 0;
        model_proto = 1'b0;
        free_cyc = cyc;
    endtask

    // Request is held until accepted; afterwards the bus carries noise the DUT must ignore.
    task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                       input line_t data, input int abort_beat);
        int    a, first, idx;
        exp_t  e;
        bit    is_wr;
        is_wr = wr && !rd;
        idx   = line_of(addr);
        a     = (cyc > free_cyc) ? cyc : free_cyc;
        first = a + LAT + 1;
        for (int k = 0; k < 4; k++) begin
            if (k < abort_beat) begin
                e.is_rd = rd;
                e.tag   = first + k;
                e.data  = model_mem[idx][64*k +: 64];
                exp_q.push_back(e);
            end
        end
        if (is_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (k < abort_beat) model_mem[idx][64*k +: 64] = data[64*k +: 64];
            end
        end
        if (rd && wr) model_proto = 1'b1;
        while (cyc <= a) begin
            read_i = rd;
            write_i = wr;
            address_i = addr;
            burst_i = {$urandom, $urandom};
            step();
        end
        while (cyc < first + 4) begin
            if (cyc == first + abort_beat) begin
                do_reset();
                return;
            end
            read_i = 1'($urandom);
            write_i = 1'($urandom);
            address_i = $urandom;
            if (is_wr && cyc >= first) burst_i = data[64*(cyc-first) +: 64];
            else burst_i = {$urandom, $urandom};
            step();
        end
        read_i = 1'b0;
        write_i = 1'b0;
        free_cyc = first + 5;
        if (rd) model_rd++;
        if (is_wr) model_wr++;
    endtask

    task automatic lat0_test();
        bit exp_r[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        z_read = 1'b1;
        z_addr = 32'h0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("lat0_resp_c%0d", k), 64'(z_resp), 64'(exp_r[k]));
            if (k == 5) check("lat0_done_burst", z_burst_o, 64'd0);
        end
        z_read = 1'b0;
        repeat (6) step();
        check("lat0_rdcnt", 64'(z_rdcnt), 64'd2);
    endtask

    function automatic line_t rand_line();
        line_t l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    task automatic gap();
        int g;
        g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++) step();
    endtask

    initial begin
        line_t pa, pb;
        int    op;
        #2;
        do_reset();

        txn(1'b0, 1'b1, 32'h40, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 4);
        txn(1'b1, 1'b0, 32'h40, '0, 4);
        step();
        check("first_wrcnt", 64'(write_count_o), 64'd1);
        check("first_rdcnt", 64'(read_count_o), 64'd1);
        check("first_proto", 64'(proto_err_o), 64'd0);

        lat0_test();
        free_cyc = cyc;

        pa = rand_line();
        pb = rand_line();
        txn(1'b0, 1'b1, 32'h000, pa, 4);
        txn(1'b0, 1'b1, 32'h200, pb, 4);
        txn(1'b1, 1'b0, 32'h000, '0, 4);

        txn(1'b0, 1'b1, 32'h80, rand_line(), 4);
        txn(1'b1, 1'b1, 32'h80, rand_line(), 4);
        txn(1'b1, 1'b0, 32'h80, '0, 4);
        step();
        check("proto_set", 64'(proto_err_o), 64'd1);

        for (int i = 0; i < NLINES; i++) begin
            txn(1'b0, 1'b1, {$urandom_range(0, 255), 4'(i), 5'($urandom)}, rand_line(), 4);
            gap();
        end
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            if (op < 5) txn(1'b1, 1'b0, $urandom, '0, 4);
            else if (op < 9) txn(1'b0, 1'b1, $urandom, rand_line(), 4);
            else txn(1'b1, 1'b1, $urandom, rand_line(), 4);
            gap();
        end
        repeat (2) step();
        check("rand_rdcnt", 64'(read_count_o), 64'(model_rd));
        check("rand_wrcnt", 64'(write_count_o), 64'(model_wr));
        check("rand_proto", 64'(proto_err_o), 64'(model_proto));

        txn(1'b0, 1'b1, 32'hA0, rand_line(), 2);
        txn(1'b1, 1'b0, 32'hA0, '0, 4);
        repeat (2) step();
        check("post_rst_rdcnt", 64'(read_count_o), 64'd1);
        check("post_rst_wrcnt", 64'(write_count_o), 64'd0);
        check("post_rst_proto", 64'(proto_err_o), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
